vx_cluster_ctrl: RTL and testbench
==================================

// Module: vx_cluster_ctrl
// PURPOSE
//  Launch controller for one cluster. It latches a host start command and startup address,
//  then sequences the per-core resets: hold all, then staggered release. It waits for all
//  cores to go idle, drains outstanding memory reads at the cluster memory port, and
//  reports completion. It also handles abort and run-timeout.
// PARAMETERS
//  NUM_CORES   4   cores sequenced; core i released i-th
//  ADDR_WIDTH  32  startup address width
//  RESET_HOLD  8   cycles all core resets held after start (>=1)
//  STAGGER     2   cycles between successive core releases (>=1)
//  TMO_WIDTH   16  timeout counter/limit width
//  OUTS_WIDTH  8   outstanding-read counter width
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous, active-low reset
//  start_valid   in   1           launch request
//  start_addr    in   ADDR_WIDTH  startup PC for all cores
//  start_ready   out  1           1 only in IDLE; launch accepted on valid&ready
//  abort         in   1           level; stop current launch
//  timeout_limit in   TMO_WIDTH   max RUN cycles; 0 = no timeout
//  startup_addr  out  ADDR_WIDTH  latched start_addr, stable until next launch
//  core_reset    out  NUM_CORES   active-high per-core reset
//  core_busy     in   NUM_CORES   per-core busy
//  mem_rd_fire   in   1           cluster mem read request handshake (valid&ready&!rw)
//  mem_rsp_fire  in   1           cluster mem response handshake (valid&ready)
//  busy          out  1           state != IDLE
//  done          out  1           1-cycle pulse at end of launch
//  error         out  1           with done: launch aborted/timed out; sticky until next accept
//  proto_err     out  1           sticky: response seen with zero outstanding; cleared on accept
//  state         out  3           FSM state encoding (debug)
// BEHAVIOUR
//  Reset values: state=IDLE(0), core_reset=all 1, startup_addr=0.
//  Reset values: start_ready=1, busy=done=error=proto_err=0, counters=0.
//  Reset asserted mid-launch returns to these values immediately.
//  FSM (registered outputs):
//   IDLE(0): accept -> latch addr, clear error/proto_err, cnt=0 -> HOLD.
//   HOLD(1): core_reset=all 1 for RESET_HOLD cycles -> RELEASE.
//   RELEASE(2): bit i cleared at cycle i*STAGGER of RELEASE.
//    After bit N-1 is cleared -> RUN next cycle.
//   RUN(3): core_busy==0 on 2 consecutive cycles -> DRAIN.
//    Each RUN cycle increments tmo counter; counter==timeout_limit (!=0) -> timeout.
//   DRAIN(4): outstanding==0 -> DONE.
//   DONE(5): done=1 one cycle; core_reset=all 1 -> IDLE.
//  Abort/timeout from HOLD/RELEASE/RUN: core_reset=all 1 next cycle, error set -> DRAIN.
//   Abort in DRAIN or DONE is ignored; abort in IDLE is ignored.
//  Outstanding counter (OUTS_WIDTH, counts in every state):
//   +1 on rd_fire, -1 on rsp_fire, unchanged on both.
//   Saturates at max (no wrap). rsp_fire at 0 holds 0 and sets proto_err.
//  start_valid outside IDLE is not accepted; the launch holds no pending request.
// TESTING
//  Nominal: N=4, HOLD=8, STAGGER=2, addr=0x80000000 -> releases 2 cycles apart.
//   -> busy drop + 0 outstanding -> done pulse, error=0, startup_addr=0x80000000.
//  Drain: 3 rd_fire during RUN, cores idle -> stays DRAIN until 3rd rsp_fire -> DONE next cycle.
//  Timeout: limit=20, core0 busy forever -> error=1 with done, all core_reset=1.
//  Abort in RELEASE after core1 released -> resets reasserted next cycle -> DRAIN -> done+error.
//  Counter edges: simultaneous rd/rsp fire leaves count; rsp at 0 -> proto_err=1, count 0.
//   proto_err cleared on next accept.
//  Async reset asserted in RUN -> core_reset=all 1, state=IDLE without clock edge.
//   start_ready=1 after deassert.

Source files
------------

// File: rtl/vx_cluster_ctrl.sv
// Cluster launch controller: latches a start command, sequences staggered per-core
// reset release, waits for the cores to go idle and for reads to drain, then reports done/error.
module vx_cluster_ctrl #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int RESET_HOLD = 8,
    parameter int STAGGER    = 2,
    parameter int TMO_WIDTH  = 16,
    parameter int OUTS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  start_ready,
    input  logic                  abort,
    input  logic [TMO_WIDTH-1:0]  timeout_limit,
    output logic [ADDR_WIDTH-1:0] startup_addr,
    output logic [NUM_CORES-1:0]  core_reset,
    input  logic [NUM_CORES-1:0]  core_busy,
    input  logic                  mem_rd_fire,
    input  logic                  mem_rsp_fire,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  proto_err,
    output logic [2:0]            state
);

    localparam int LAST_REL = (NUM_CORES - 1) * STAGGER;
    localparam int CNT_MAX  = (RESET_HOLD > LAST_REL) ? RESET_HOLD : LAST_REL;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CORES-1:0]  core_reset_q, core_reset_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TMO_WIDTH-1:0]  tmo_q, tmo_d, tmo_inc;
    logic [OUTS_WIDTH-1:0] outs_q, outs_d;
    logic                  idle_q, idle_d;
    logic                  error_q, error_d;
    logic                  perr_q, perr_d;
    logic                  accept, in_launch, timed_out, stop_req;

    assign accept    = start_valid && (state_q == S_IDLE);
    assign tmo_inc   = tmo_q + 1'b1;
    assign in_launch = (state_q == S_HOLD) || (state_q == S_RELEASE) || (state_q == S_RUN);
    assign timed_out = (state_q == S_RUN) && (timeout_limit != '0) && (tmo_inc == timeout_limit);
    assign stop_req  = in_launch && (abort || timed_out);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_reset_q <= '1;
            addr_q       <= '0;
            tmo_q        <= '0;
            outs_q       <= '0;
            idle_q       <= 1'b0;
            error_q      <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            addr_q       <= addr_d;
            tmo_q        <= tmo_d;
            outs_q       <= outs_d;
            idle_q       <= idle_d;
            error_q      <= error_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_reset_d = core_reset_q;
        addr_d       = addr_q;
        error_d      = error_q;
        tmo_d        = tmo_q;
        idle_d       = idle_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d       = start_addr;
                    error_d      = 1'b0;
                    cnt_d        = '0;
                    core_reset_d = '1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (cnt_q == CNT_W'(i * STAGGER)) core_reset_d[i] = 1'b0;
                end
                if (cnt_q == CNT_W'(LAST_REL)) begin
                    tmo_d   = '0;
                    idle_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                tmo_d  = tmo_inc;
                // Idle must be observed on two consecutive cycles to filter single-cycle gaps.
                idle_d = (core_busy == '0);
                if (idle_q && (core_busy == '0)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outs_q == '0) begin
                    core_reset_d = '1;
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop_req) begin
            core_reset_d = '1;
            error_d      = 1'b1;
            state_d      = S_DRAIN;
        end
    end

    // Outstanding-read tracking runs in every state, independent of the launch FSM.
    always_comb begin
        outs_d = outs_q;
        perr_d = accept ? 1'b0 : perr_q;
        if (mem_rd_fire && !mem_rsp_fire) begin
            if (outs_q != '1) outs_d = outs_q + 1'b1;
        end else if (!mem_rd_fire && mem_rsp_fire) begin
            if (outs_q == '0) perr_d = 1'b1;
            else              outs_d = outs_q - 1'b1;
        end
    end

    assign start_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign error        = error_q;
    assign proto_err    = perr_q;
    assign startup_addr = addr_q;
    assign core_reset   = core_reset_q;
    assign state        = state_q;

endmodule

// File: tb/tb_vx_cluster_ctrl.sv
// Self-checking bench for vx_cluster_ctrl: randomized launches checked against
// launch timings and an outstanding-read model derived from the behavioural rules.
module tb_vx_cluster_ctrl;

    localparam int NUM_CORES  = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int RESET_HOLD = 8;
    localparam int STAGGER    = 2;
    localparam int TMO_WIDTH  = 16;
    localparam int OUTS_WIDTH = 8;
    localparam int K_RUN      = RESET_HOLD + 1 + (NUM_CORES - 1) * STAGGER;
    localparam int OUTS_MAX   = (1 << OUTS_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start_valid;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  start_ready;
    logic                  abort;
    logic [TMO_WIDTH-1:0]  timeout_limit;
    logic [ADDR_WIDTH-1:0] startup_addr;
    logic [NUM_CORES-1:0]  core_reset;
    logic [NUM_CORES-1:0]  core_busy;
    logic                  mem_rd_fire;
    logic                  mem_rsp_fire;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  proto_err;
    logic [2:0]            state;

    int checks   = 0;
    int failures = 0;
    int model_outs = 0;
    bit model_perr = 1'b0;

    vx_cluster_ctrl #(
        .NUM_CORES(NUM_CORES), .ADDR_WIDTH(ADDR_WIDTH), .RESET_HOLD(RESET_HOLD),
        .STAGGER(STAGGER), .TMO_WIDTH(TMO_WIDTH), .OUTS_WIDTH(OUTS_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_addr(start_addr),
        .start_ready(start_ready), .abort(abort), .timeout_limit(timeout_limit),
        .startup_addr(startup_addr), .core_reset(core_reset), .core_busy(core_busy),
        .mem_rd_fire(mem_rd_fire), .mem_rsp_fire(mem_rsp_fire), .busy(busy), .done(done),
        .error(error), .proto_err(proto_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // One clock edge; the outstanding-read model follows the handshakes sampled at that edge.
    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            if (mem_rd_fire && !mem_rsp_fire) begin
                if (model_outs < OUTS_MAX) model_outs++;
            end else if (!mem_rd_fire && mem_rsp_fire) begin
                if (model_outs == 0) model_perr = 1'b1;
                else                 model_outs--;
            end
        end
        #1;
    endtask

    task automatic launch(input logic [ADDR_WIDTH-1:0] addr);
        start_addr  = addr;
        start_valid = 1'b1;
        cyc();
        start_valid = 1'b0;
        model_perr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (core_reset !== 4'hF) begin failures++; $display("FAIL reset_core_reset got=%0h exp=f", core_reset); end
        checks++; if (startup_addr !== 32'h0) begin failures++; $display("FAIL reset_startup_addr got=%0h exp=0", startup_addr); end
        checks++; if (start_ready !== 1'b1) begin failures++; $display("FAIL reset_start_ready got=%0b exp=1", start_ready); end
        checks++; if ({busy, done, error, proto_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, proto_err}); end
        reset = 1'b1;
        cyc();
        checks++; if (state !== 3'd0 || start_ready !== 1'b1) begin failures++; $display("FAIL reset_release_idle got=%0d/%0b exp=0/1", state, start_ready); end
    endtask

    task automatic test_nominal();
        int rel[NUM_CORES];
        int dur[NUM_CORES];
        int kz, k_drain, k_done;
        logic [ADDR_WIDTH-1:0] addr;
        logic [NUM_CORES-1:0] er, bz;
        logic [2:0] es;
        logic ed;
        for (int it = 0; it < 3; it++) begin
            addr = (it == 0) ? 32'h8000_0000 : $urandom;
            timeout_limit = (it == 1) ? 16'd1000 : 16'd0;
            kz = 0;
            for (int i = 0; i < NUM_CORES; i++) begin
                rel[i] = RESET_HOLD + 1 + i * STAGGER;
                dur[i] = $urandom_range(1, 12);
                if (rel[i] + dur[i] > kz) kz = rel[i] + dur[i];
            end
            k_drain = kz + 2;
            k_done  = kz + 3;
            core_busy = '0;
            launch(addr);
            for (int k = 0; k <= k_done + 1; k++) begin
                if (k < RESET_HOLD)   es = 3'd1;
                else if (k < K_RUN)   es = 3'd2;
                else if (k < k_drain) es = 3'd3;
                else if (k == k_drain) es = 3'd4;
                else if (k == k_done) es = 3'd5;
                else                  es = 3'd0;
                for (int i = 0; i < NUM_CORES; i++) begin
                    er[i] = (k >= k_done) || (k < rel[i]);
                    bz[i] = (k >= rel[i]) && (k < rel[i] + dur[i]);
                end
                ed = (k == k_done);
                checks++; if (state !== es) begin failures++; $display("FAIL nominal_state k=%0d got=%0d exp=%0d", k, state, es); end
                checks++; if (core_reset !== er) begin failures++; $display("FAIL nominal_core_reset k=%0d got=%b exp=%b", k, core_reset, er); end
                checks++; if (done !== ed) begin failures++; $display("FAIL nominal_done k=%0d got=%0b exp=%0b", k, done, ed); end
                core_busy = bz;
                cyc();
            end
            core_busy = '0;
            checks++; if (startup_addr !== addr) begin failures++; $display("FAIL nominal_startup_addr got=%0h exp=%0h", startup_addr, addr); end
            checks++; if (error !== 1'b0) begin failures++; $display("FAIL nominal_error got=%0b exp=0", error); end
        end
        timeout_limit = '0;
    endtask

    task automatic test_drain();
        int nrd, n, w, ex;
        nrd = $urandom_range(2, 6);
        timeout_limit = '0;
        core_busy = '1;
        launch($urandom);
        repeat (K_RUN) cyc();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL drain_in_run got=%0d exp=3", state); end
        mem_rd_fire = 1'b1;
        repeat (nrd) cyc();
        mem_rd_fire = 1'b0;
        core_busy = '0;
        for (w = 0; w < 10 && state !== 3'd4; w++) cyc();
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain_reach got=%0d exp=4", state); end
        ex = $urandom_range(2, 8);
        for (int j = 0; j < ex; j++) begin
            checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain_hold j=%0d got=%0d exp=4", j, state); end
            cyc();
        end
        n = model_outs;
        for (int j = 0; j < n; j++) begin
            mem_rsp_fire = 1'b1;
            cyc();
            mem_rsp_fire = 1'b0;
            checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain_rsp j=%0d got=%0d exp=4", j, state); end
            repeat ($urandom_range(0, 2)) begin
                cyc();
                if (j < n - 1) begin
                    checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain_gap j=%0d got=%0d exp=4", j, state); end
                end
            end
            if (j == n - 1) break;
        end
        if (state === 3'd4) cyc();
        checks++; if (state !== 3'd5 || done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL drain_done got=%0d/%0b/%0b exp=5/1/0", state, done, error); end
        cyc();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL drain_idle got=%0d exp=0", state); end
    endtask

    task automatic test_timeout();
        int lim;
        for (int it = 0; it < 2; it++) begin
            lim = (it == 0) ? 20 : $urandom_range(1, 40);
            timeout_limit = TMO_WIDTH'(lim);
            core_busy = 4'b0001;
            launch($urandom);
            for (int k = 0; k <= K_RUN + lim + 1; k++) begin
                if (k == K_RUN + lim - 1) begin
                    checks++; if (state !== 3'd3) begin failures++; $display("FAIL timeout_run lim=%0d got=%0d exp=3", lim, state); end
                end
                if (k == K_RUN + lim) begin
                    checks++; if (state !== 3'd4 || core_reset !== 4'hF || error !== 1'b1) begin failures++; $display("FAIL timeout_drain lim=%0d got=%0d/%h/%0b exp=4/f/1", lim, state, core_reset, error); end
                end
                if (k == K_RUN + lim + 1) begin
                    checks++; if (state !== 3'd5 || done !== 1'b1 || error !== 1'b1) begin failures++; $display("FAIL timeout_done lim=%0d got=%0d/%0b/%0b exp=5/1/1", lim, state, done, error); end
                end
                cyc();
            end
            core_busy = '0;
        end
        timeout_limit = '0;
    endtask

    task automatic test_abort();
        int kab;
        logic [NUM_CORES-1:0] er;
        kab = RESET_HOLD + 1 + STAGGER + 1;
        for (int i = 0; i < NUM_CORES; i++) er[i] = !(kab >= RESET_HOLD + 1 + i * STAGGER);
        core_busy = '1;
        launch($urandom);
        repeat (kab) cyc();
        checks++; if (state !== 3'd2 || core_reset !== er) begin failures++; $display("FAIL abort_pre got=%0d/%b exp=2/%b", state, core_reset, er); end
        abort = 1'b1;
        cyc();
        checks++; if (state !== 3'd4 || core_reset !== 4'hF || error !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_drain got=%0d/%h/%0b/%0b exp=4/f/1/0", state, core_reset, error, done); end
        cyc();
        checks++; if (state !== 3'd5 || done !== 1'b1 || error !== 1'b1) begin failures++; $display("FAIL abort_done got=%0d/%0b/%0b exp=5/1/1", state, done, error); end
        cyc();
        checks++; if (state !== 3'd0 || error !== 1'b1 || start_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%0d/%0b/%0b exp=0/1/1", state, error, start_ready); end
        repeat (2) cyc();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL abort_ignored_idle got=%0d exp=0", state); end
        abort = 1'b0;
        core_busy = '0;
        launch($urandom);
        checks++; if (state !== 3'd1 || error !== 1'b0) begin failures++; $display("FAIL abort_relaunch got=%0d/%0b exp=1/0", state, error); end
        repeat (K_RUN + 3) cyc();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL abort_clean_done got=%0b/%0b exp=1/0", done, error); end
        cyc();
    endtask

    task automatic test_counter_edges();
        mem_rd_fire = 1'b1; mem_rsp_fire = 1'b1;
        cyc();
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL cnt_both_at_zero got=%0b exp=0", proto_err); end
        mem_rd_fire = 1'b0;
        cyc();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL cnt_rsp_at_zero got=%0b exp=1", proto_err); end
        mem_rsp_fire = 1'b0; mem_rd_fire = 1'b1;
        cyc();
        mem_rsp_fire = 1'b1;
        cyc();
        mem_rd_fire = 1'b0;
        cyc();
        mem_rsp_fire = 1'b0;
        checks++; if (proto_err !== model_perr) begin failures++; $display("FAIL cnt_sticky got=%0b exp=%0b", proto_err, model_perr); end
        core_busy = '0;
        launch($urandom);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL cnt_clear_on_accept got=%0b exp=0", proto_err); end
        repeat (K_RUN + 3) cyc();
        checks++; if (state !== 3'd5 || done !== 1'b1) begin failures++; $display("FAIL cnt_zero_drain got=%0d/%0b exp=5/1", state, done); end
        cyc();
    endtask

    task automatic test_random_traffic();
        int n;
        for (int c = 0; c < 200; c++) begin
            mem_rd_fire  = 1'($urandom_range(0, 1));
            mem_rsp_fire = 1'($urandom_range(0, 1));
            cyc();
            checks++; if (proto_err !== model_perr) begin failures++; $display("FAIL rand_proto c=%0d got=%0b exp=%0b", c, proto_err, model_perr); end
        end
        mem_rd_fire = 1'b0;
        n = model_outs;
        mem_rsp_fire = 1'b1;
        repeat (n) cyc();
        mem_rsp_fire = 1'b0;
        checks++; if (proto_err !== model_perr) begin failures++; $display("FAIL rand_proto_final got=%0b exp=%0b", proto_err, model_perr); end
        core_busy = '0;
        launch($urandom);
        repeat (K_RUN + 2) cyc();
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL rand_drain got=%0d exp=4", state); end
        cyc();
        checks++; if (state !== 3'd5 || done !== 1'b1) begin failures++; $display("FAIL rand_done got=%0d/%0b exp=5/1", state, done); end
        cyc();
    endtask

    task automatic test_saturation();
        int n1, n;
        n1 = $urandom_range(OUTS_MAX + 1, OUTS_MAX + 40);
        mem_rd_fire = 1'b1;
        repeat (n1) cyc();
        mem_rd_fire = 1'b0;
        n = model_outs - 1;
        mem_rsp_fire = 1'b1;
        repeat (n) cyc();
        mem_rsp_fire = 1'b0;
        core_busy = '0;
        launch($urandom);
        repeat (K_RUN + 2) cyc();
        for (int j = 0; j < 4; j++) begin
            checks++; if (state !== 3'd4) begin failures++; $display("FAIL sat_stall j=%0d got=%0d exp=4", j, state); end
            cyc();
        end
        mem_rsp_fire = 1'b1;
        cyc();
        mem_rsp_fire = 1'b0;
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL sat_last_rsp got=%0d exp=4", state); end
        cyc();
        checks++; if (state !== 3'd5 || done !== 1'b1 || proto_err !== 1'b0) begin failures++; $display("FAIL sat_done got=%0d/%0b/%0b exp=5/1/0", state, done, proto_err); end
        cyc();
    endtask

    task automatic test_async_reset();
        core_busy = '1;
        launch($urandom);
        repeat (K_RUN + 2) cyc();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0d exp=3", state); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || core_reset !== 4'hF || busy !== 1'b0) begin failures++; $display("FAIL areset_immediate got=%0d/%h/%0b exp=0/f/0", state, core_reset, busy); end
        model_outs = 0;
        model_perr = 1'b0;
        #2;
        reset = 1'b1;
        core_busy = '0;
        cyc();
        checks++; if (start_ready !== 1'b1 || state !== 3'd0 || error !== 1'b0) begin failures++; $display("FAIL areset_after got=%0b/%0d/%0b exp=1/0/0", start_ready, state, error); end
    endtask

    initial begin
        reset         = 1'b0;
        start_valid   = 1'b0;
        start_addr    = '0;
        abort         = 1'b0;
        timeout_limit = '0;
        core_busy     = '0;
        mem_rd_fire   = 1'b0;
        mem_rsp_fire  = 1'b0;
        test_reset();
        test_nominal();
        test_drain();
        test_timeout();
        test_abort();
        test_counter_edges();
        test_random_traffic();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
